// File: rtl/laser_cover_counter.sv
// ---------------------------------------------------------------------------
// laser_cover_counter
//   Downstream scorer for the two-shot laser solver. It snoops the same
//   NUM_TARGETS-beat X/Y load stream the solver sees and stores it locally.
//   On the rising edge of the solver's DONE it latches the two chosen centres
//   and rescans the stored targets, LANES targets per cycle. It then reports
//   how many targets fall inside C1, inside C2, and inside either circle.
//
// Ports
//   CLK              in   clock, rising edge
//   RST              in   asynchronous active-high reset
//   IN_VALID         in   X/Y carry a target this cycle
//   X, Y       [3:0] in   target coordinate
//   DONE_IN          in   solver DONE level (only its rising edge is used)
//   C1X, C1Y   [3:0] in   solver centre 1
//   C2X, C2Y   [3:0] in   solver centre 2
//   COUNT      [5:0] out  targets inside C1 or C2
//   C1_CNT     [5:0] out  targets inside C1
//   C2_CNT     [5:0] out  targets inside C2
//   BUSY             out  high while the rescan is running
//   VALID            out  one-cycle pulse when the counts have just updated
// ---------------------------------------------------------------------------
module laser_cover_counter #(
  parameter int NUM_TARGETS = 40,
  parameter int LANES       = 4,
  parameter int RADIUS_SQ   = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       DONE_IN,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic [5:0] COUNT,
  output logic [5:0] C1_CNT,
  output logic [5:0] C2_CNT,
  output logic       BUSY,
  output logic       VALID
);

  localparam int PTR_W = 6;
  localparam logic [PTR_W-1:0] LAST_WR  = PTR_W'(NUM_TARGETS - 1);
  localparam logic [PTR_W-1:0] LAST_GRP = PTR_W'(NUM_TARGETS - LANES);
  localparam logic [PTR_W-1:0] STEP     = PTR_W'(LANES);

  typedef enum logic [1:0] {
    S_LOAD,
    S_WAIT,
    S_SCAN,
    S_REPORT
  } state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_done_d;
  logic [5:0]       r_acc_u;
  logic [5:0]       r_acc_1;
  logic [5:0]       r_acc_2;

  // Target store: {X,Y} per entry. Contents are data only, never reset.
  logic [7:0]       r_mem [NUM_TARGETS];

  // Centres captured on the DONE edge so the scan ignores later input changes.
  logic [3:0]       r_c1x, r_c1y, r_c2x, r_c2y;

  logic             w_rise;
  logic [7:0]       w_tgt [LANES];
  logic [LANES-1:0] w_in1;
  logic [LANES-1:0] w_in2;
  logic [5:0]       w_n1;
  logic [5:0]       w_n2;
  logic [5:0]       w_nu;

  // Inclusive circle test. Differences are taken as magnitudes so nothing
  // wraps; the squared sum peaks at 450 and fits 9 bits.
  function automatic logic in_circle(input logic [3:0] x, input logic [3:0] y,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] sx, sy;
    logic [8:0] sum;
    dx  = (x >= cx) ? (x - cx) : (cx - x);
    dy  = (y >= cy) ? (y - cy) : (cy - y);
    sx  = {4'd0, dx} * {4'd0, dx};
    sy  = {4'd0, dy} * {4'd0, dy};
    sum = {1'b0, sx} + {1'b0, sy};
    return (sum <= 9'(RADIUS_SQ));
  endfunction

  assign w_rise = DONE_IN & ~r_done_d;

  // Evaluate the current group of LANES targets against both latched centres.
  always_comb begin
    w_in1 = '0;
    w_in2 = '0;
    w_n1  = '0;
    w_n2  = '0;
    w_nu  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_tgt[l] = r_mem[r_rd_ptr + PTR_W'(l)];
      w_in1[l] = in_circle(w_tgt[l][7:4], w_tgt[l][3:0], r_c1x, r_c1y);
      w_in2[l] = in_circle(w_tgt[l][7:4], w_tgt[l][3:0], r_c2x, r_c2y);
      w_n1     = w_n1 + 6'(w_in1[l]);
      w_n2     = w_n2 + 6'(w_in2[l]);
      w_nu     = w_nu + 6'(w_in1[l] | w_in2[l]);
    end
  end

  always_ff @(posedge CLK) begin
    if (r_state == S_LOAD && IN_VALID) begin
      r_mem[r_wr_ptr] <= {X, Y};
    end
  end

  always_ff @(posedge CLK) begin
    if (r_state == S_WAIT && w_rise) begin
      r_c1x <= C1X;
      r_c1y <= C1Y;
      r_c2x <= C2X;
      r_c2y <= C2Y;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_LOAD;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_done_d <= 1'b0;
      r_acc_u  <= '0;
      r_acc_1  <= '0;
      r_acc_2  <= '0;
      COUNT    <= '0;
      C1_CNT   <= '0;
      C2_CNT   <= '0;
      BUSY     <= 1'b0;
      VALID    <= 1'b0;
    end else begin
      r_done_d <= DONE_IN;
      VALID    <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (IN_VALID) begin
            if (r_wr_ptr == LAST_WR) begin
              r_wr_ptr <= '0;
              r_state  <= S_WAIT;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (w_rise) begin
            r_acc_u  <= '0;
            r_acc_1  <= '0;
            r_acc_2  <= '0;
            r_rd_ptr <= '0;
            BUSY     <= 1'b1;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_acc_u  <= r_acc_u + w_nu;
          r_acc_1  <= r_acc_1 + w_n1;
          r_acc_2  <= r_acc_2 + w_n2;
          r_rd_ptr <= r_rd_ptr + STEP;
          if (r_rd_ptr == LAST_GRP) begin
            // Outputs are loaded with the final totals on the way into
            // REPORT so they and VALID are visible during the REPORT cycle.
            r_rd_ptr <= '0;
            COUNT    <= r_acc_u + w_nu;
            C1_CNT   <= r_acc_1 + w_n1;
            C2_CNT   <= r_acc_2 + w_n2;
            VALID    <= 1'b1;
            BUSY     <= 1'b0;
            r_state  <= S_REPORT;
          end
        end
        S_REPORT: begin
          r_state <= S_LOAD;
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

endmodule
